// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM controller: FSM state encoding,
// default geometry and helpers for sizing the beat counter.
package sram_ctrl_pkg;

  localparam int          DEF_DATA_W      = 32;
  localparam int          DEF_DQ_W        = 16;
  localparam int          DEF_SRAM_ADDR_W = 18;
  localparam int          DEF_WAIT        = 1;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;

  // Wait-state counter is sized for the full 0..15 range.
  localparam int          WCNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  function automatic int calcBeats(input int dataW, input int dqW);
    return dataW / dqW;
  endfunction

  function automatic int beatIdxW(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Pipeline-side load/store handshake between the memory stage (master)
// and the SRAM controller (slave).
interface sram_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              rd_en;
  logic              wr_en;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (
    output rd_en,
    output wr_en,
    output addr,
    output wdata,
    input  rdata,
    input  ready
  );

  modport slave (
    input  rd_en,
    input  wr_en,
    input  addr,
    input  wdata,
    output rdata,
    output ready
  );

endinterface

// File: rtl/sram_ctrl_timer.sv
// Beat and wait-state sequencing for one SRAM access; flags the last cycle
// of each beat and the last cycle of the whole access.
module sram_ctrl_timer
  import sram_ctrl_pkg::*;
#(
  parameter int BEATS  = 2,
  parameter int WAIT   = 1,
  parameter int BEAT_W = beatIdxW(BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              run_i,
  output logic [BEAT_W-1:0] beat_o,
  output logic              beatLast_o,
  output logic              accessLast_o
);

  localparam logic [WCNT_W-1:0] WAIT_CNT  = WCNT_W'(WAIT);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  assign beat_o       = beat_q;
  assign beatLast_o   = (wcnt_q == WAIT_CNT);
  assign accessLast_o = beatLast_o && (beat_q == LAST_BEAT);

  always_comb begin
    wcnt_d = wcnt_q;
    beat_d = beat_q;
    if (start_i) begin
      wcnt_d = '0;
      beat_d = '0;
    end else if (run_i) begin
      if (beatLast_o) begin
        wcnt_d = '0;
        beat_d = beat_q + BEAT_W'(1);
      end else begin
        wcnt_d = wcnt_q + WCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
      beat_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Memory-stage to asynchronous SRAM bridge: splits each pipeline word into
// little-endian SRAM beats with wait states and stalls the pipeline via ready.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int          DATA_W      = DEF_DATA_W,
  parameter int          DQ_W        = DEF_DQ_W,
  parameter int          SRAM_ADDR_W = DEF_SRAM_ADDR_W,
  parameter int          WAIT        = DEF_WAIT,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sram_ctrl_if.slave             bus,
  output logic [SRAM_ADDR_W-1:0] sram_address_o,
  output logic                   sram_we_n_o,
  inout  wire  [DQ_W-1:0]        sram_dq_io
);

  localparam int          BEATS      = calcBeats(DATA_W, DQ_W);
  localparam int          BEAT_W     = beatIdxW(BEATS);
  localparam int          WORD_SHIFT = $clog2(DATA_W / 8);
  localparam logic [31:0] BEATS_32   = 32'(BEATS);

  state_e                 state_q, state_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [SRAM_ADDR_W-1:0] sramAddr_q, sramAddr_d;
  logic                   sramWeN_q, sramWeN_d;

  logic                   request;
  logic                   start;
  logic                   running;
  logic [31:0]            wordIdx;
  logic [SRAM_ADDR_W-1:0] baseWord;
  logic [BEAT_W-1:0]      beat;
  logic                   beatLast;
  logic                   accessLast;

  assign request  = bus.rd_en | bus.wr_en;
  assign start    = (state_q == IDLE) && request;
  assign running  = (state_q == ACCESS);

  // Pipeline byte address to first SRAM word; wraps modulo the SRAM size.
  assign wordIdx  = (bus.addr - BASE_ADDR) >> WORD_SHIFT;
  assign baseWord = SRAM_ADDR_W'(wordIdx * BEATS_32);

  sram_ctrl_timer #(
    .BEATS (BEATS),
    .WAIT  (WAIT),
    .BEAT_W(BEAT_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .run_i       (running),
    .beat_o      (beat),
    .beatLast_o  (beatLast),
    .accessLast_o(accessLast)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (request) state_d = ACCESS;
      ACCESS:  if (accessLast) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = 1'b0;
    case (state_q)
      IDLE:    bus.ready = !request;
      DONE:    bus.ready = 1'b1;
      default: bus.ready = 1'b0;
    endcase
  end

  // Store data is shifted down one slice per beat so the bus always drives
  // the low slice; loads land directly in their beat's slice of rdata.
  always_comb begin
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    sramAddr_d = sramAddr_q;
    sramWeN_d  = sramWeN_q;
    if (start) begin
      wdata_d    = bus.wdata;
      sramAddr_d = baseWord;
      sramWeN_d  = !bus.wr_en;
    end else if (running) begin
      if (sramWeN_q && beatLast) begin
        rdata_d[beat*DQ_W +: DQ_W] = sram_dq_io;
      end
      if (accessLast) begin
        sramWeN_d = 1'b1;
      end else if (beatLast) begin
        sramAddr_d = sramAddr_q + SRAM_ADDR_W'(1);
        wdata_d    = wdata_q >> DQ_W;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_q    <= '0;
      rdata_q    <= '0;
      sramAddr_q <= '0;
      sramWeN_q  <= 1'b1;
    end else begin
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      sramAddr_q <= sramAddr_d;
      sramWeN_q  <= sramWeN_d;
    end
  end

  assign bus.rdata      = rdata_q;
  assign sram_address_o = sramAddr_q;
  assign sram_we_n_o    = sramWeN_q;
  assign sram_dq_io     = sramWeN_q ? {DQ_W{1'bz}} : wdata_q[DQ_W-1:0];

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed scoreboard bench for sram_ctrl: default geometry with a behavioural
// SRAM, plus WAIT=0, WAIT=3 and 64-bit instances for latency and beat order.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int MEM_DEPTH      = 1024;
  localparam int TIMEOUT_CYCLES = 40;

  typedef struct {
    string       tag;
    int          sel;
    int          low;
    logic [63:0] rdata;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  int          checks   = 0;
  int          failures = 0;
  exp_t        sb[$];
  logic [63:0] lastLoad [4];
  int          lowExp   [4] = '{5, 3, 9, 9};
  logic [15:0] refMem   [MEM_DEPTH];
  logic [15:0] memA     [MEM_DEPTH];
  logic [15:0] memD     [MEM_DEPTH];

  always #5 clk = ~clk;

  sram_ctrl_if #(.DATA_W(32)) busA ();
  sram_ctrl_if #(.DATA_W(32)) busB ();
  sram_ctrl_if #(.DATA_W(32)) busC ();
  sram_ctrl_if #(.DATA_W(64)) busD ();

  wire  [15:0] dqA, dqB, dqC, dqD;
  logic [17:0] addrA, addrB, addrC, addrD;
  logic        weNA, weNB, weNC, weND;

  sram_ctrl #(.WAIT(1)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(busA),
    .sram_address_o(addrA), .sram_we_n_o(weNA), .sram_dq_io(dqA)
  );
  sram_ctrl #(.WAIT(0)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(busB),
    .sram_address_o(addrB), .sram_we_n_o(weNB), .sram_dq_io(dqB)
  );
  sram_ctrl #(.WAIT(3)) dutC (
    .clk(clk), .rst_n(rst_n), .bus(busC),
    .sram_address_o(addrC), .sram_we_n_o(weNC), .sram_dq_io(dqC)
  );
  sram_ctrl #(.DATA_W(64), .WAIT(1)) dutD (
    .clk(clk), .rst_n(rst_n), .bus(busD),
    .sram_address_o(addrD), .sram_we_n_o(weND), .sram_dq_io(dqD)
  );

  // Behavioural asynchronous SRAM: drives the bus whenever not being written.
  assign dqA = weNA ? memA[addrA[9:0]] : 16'hzzzz;

  always @(negedge clk) begin
    if (!weNA) memA[addrA[9:0]] <= dqA;
  end

  always @(negedge clk) begin
    if (!weND) memD[addrD[9:0]] <= dqD;
  end

  task automatic expectEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] refIndex(input logic [31:0] a);
    logic [31:0] word;
    logic [17:0] sramWord;
    word     = (a - 32'd1024) >> 2;
    sramWord = 18'(word * 32'd2);
    return sramWord[9:0];
  endfunction

  function automatic logic readyOf(input int sel);
    case (sel)
      0:       return busA.ready;
      1:       return busB.ready;
      2:       return busC.ready;
      default: return busD.ready;
    endcase
  endfunction

  function automatic logic [63:0] rdataOf(input int sel);
    case (sel)
      0:       return {32'h0, busA.rdata};
      1:       return {32'h0, busB.rdata};
      2:       return {32'h0, busC.rdata};
      default: return busD.rdata;
    endcase
  endfunction

  task automatic driveReq(input int sel, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [63:0] wdata);
    case (sel)
      0: begin busA.rd_en = rd; busA.wr_en = wr; busA.addr = addr; busA.wdata = wdata[31:0]; end
      1: begin busB.rd_en = rd; busB.wr_en = wr; busB.addr = addr; busB.wdata = wdata[31:0]; end
      2: begin busC.rd_en = rd; busC.wr_en = wr; busC.addr = addr; busC.wdata = wdata[31:0]; end
      default: begin busD.rd_en = rd; busD.wr_en = wr; busD.addr = addr; busD.wdata = wdata; end
    endcase
  endtask

  task automatic releaseReq(input int sel);
    driveReq(sel, 1'b0, 1'b0, 32'h0, 64'h0);
  endtask

  // Predict the outcome, queue it, then present the request.
  task automatic applyStimulus(input int sel, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [63:0] wdata,
                               input string tag);
    exp_t       e;
    logic [9:0] idx;
    if (sel == 0) begin
      idx = refIndex(addr);
      if (wr) begin
        refMem[idx]         = wdata[15:0];
        refMem[idx + 10'd1] = wdata[31:16];
      end else if (rd) begin
        lastLoad[0] = {32'h0, refMem[idx + 10'd1], refMem[idx]};
      end
    end
    e.tag   = tag;
    e.sel   = sel;
    e.low   = lowExp[sel];
    e.rdata = lastLoad[sel];
    sb.push_back(e);
    driveReq(sel, rd, wr, addr, wdata);
  endtask

  // Count ready-low cycles from the request cycle until ready rises.
  task automatic waitDone(input int sel, output int low, output bit timedOut);
    low      = 0;
    timedOut = 1'b1;
    for (int c = 0; c < TIMEOUT_CYCLES; c++) begin
      #1;
      if (readyOf(sel)) begin
        timedOut = 1'b0;
        break;
      end
      low++;
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input int sel, input int low, input bit timedOut);
    exp_t e;
    checks++;
    assert (sb.size() != 0)
    else begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      expectEq({e.tag, "_sel"}, 64'(sel), 64'(e.sel));
      expectEq({e.tag, "_timeout"}, 64'(timedOut), 64'd0);
      expectEq({e.tag, "_low_cycles"}, 64'(low), 64'(e.low));
      expectEq({e.tag, "_rdata"}, rdataOf(sel), e.rdata);
    end
  endtask

  task automatic doAccess(input int sel, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [63:0] wdata,
                          input string tag);
    int low;
    bit timedOut;
    @(negedge clk);
    applyStimulus(sel, rd, wr, addr, wdata, tag);
    waitDone(sel, low, timedOut);
    checkOutput(sel, low, timedOut);
    releaseReq(sel);
  endtask

  initial begin
    int low;
    bit timedOut;

    for (int i = 0; i < MEM_DEPTH; i++) refMem[i] = 16'h0;
    for (int s = 0; s < 4; s++) begin
      lastLoad[s] = 64'h0;
      releaseReq(s);
    end

    #2 rst_n = 1'b0;
    #1;
    expectEq("reset_ready", 64'(busA.ready), 64'd1);
    expectEq("reset_we_n", 64'(weNA), 64'd1);
    expectEq("reset_address", 64'(addrA), 64'd0);
    expectEq("reset_rdata", 64'(busA.rdata), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic store/load at default geometry");
    doAccess(0, 1'b0, 1'b1, 32'd1024, 64'hDEADBEEF, "store_1024");
    expectEq("sram0_after_store", 64'(memA[0]), 64'hBEEF);
    expectEq("sram1_after_store", 64'(memA[1]), 64'hDEAD);
    doAccess(0, 1'b1, 1'b0, 32'd1024, 64'h0, "load_1024");
    doAccess(0, 1'b0, 1'b1, 32'd1028, 64'h12345678, "store_1028");
    expectEq("sram2_after_store", 64'(memA[2]), 64'h5678);
    expectEq("sram3_after_store", 64'(memA[3]), 64'h1234);
    doAccess(0, 1'b1, 1'b0, 32'd1028, 64'h0, "load_1028");

    doAccess(0, 1'b1, 1'b1, 32'd1032, 64'hA5A55A5A, "rd_wr_both");
    expectEq("sram4_write_wins", 64'(memA[4]), 64'h5A5A);
    expectEq("sram5_write_wins", 64'(memA[5]), 64'hA5A5);

    doAccess(0, 1'b0, 1'b1, 32'd1020, 64'h0BADCAFE, "store_below_base");
    expectEq("sram_wrap_lo", 64'(memA[10'h3FE]), 64'hCAFE);
    expectEq("sram_wrap_hi", 64'(memA[10'h3FF]), 64'h0BAD);
    doAccess(0, 1'b1, 1'b0, 32'd1022, 64'h0, "load_unaligned_wrap");

    $display("[TB] back-to-back loads held across DONE");
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 32'd1024, 64'h0, "b2b_first");
    waitDone(0, low, timedOut);
    checkOutput(0, low, timedOut);
    applyStimulus(0, 1'b1, 1'b0, 32'd1028, 64'h0, "b2b_second");
    @(negedge clk);
    waitDone(0, low, timedOut);
    checkOutput(0, low, timedOut);
    releaseReq(0);

    $display("[TB] reset during a store");
    @(negedge clk);
    driveReq(0, 1'b0, 1'b1, 32'd1024, 64'hCAFEF00D);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    expectEq("midrst_we_n", 64'(weNA), 64'd1);
    expectEq("midrst_ready_req_held", 64'(busA.ready), 64'd0);
    expectEq("midrst_rdata", 64'(busA.rdata), 64'd0);
    releaseReq(0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expectEq("after_rst_idle_ready", 64'(busA.ready), 64'd1);
    expectEq("partial_write_beat0", 64'(memA[0]), 64'hF00D);
    refMem[0]   = 16'hF00D;
    lastLoad[0] = 64'h0;
    doAccess(0, 1'b1, 1'b0, 32'd1024, 64'h0, "load_after_rst");

    $display("[TB] wait-state and width variants");
    doAccess(1, 1'b0, 1'b1, 32'd1024, 64'h11112222, "wait0_store");
    doAccess(2, 1'b0, 1'b1, 32'd1024, 64'h33334444, "wait3_store");
    doAccess(3, 1'b0, 1'b1, 32'd1024, 64'h0011223344556677, "w64_store");
    expectEq("w64_sram0", 64'(memD[0]), 64'h6677);
    expectEq("w64_sram1", 64'(memD[1]), 64'h4455);
    expectEq("w64_sram2", 64'(memD[2]), 64'h2233);
    expectEq("w64_sram3", 64'(memD[3]), 64'h0011);

    checks++;
    assert (sb.size() == 0)
    else begin
      failures++;
      $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Parametrised controller between the memory stage and the external asynchronous 16-bit SRAM (behavioural SRAM model in simulation, real chip on FPGA). Splits each DATA_W-bit load/store into DATA_W/DQ_W sequential SRAM beats with programmable wait states. Holds `ready` low to freeze the pipeline until the access completes. Replaces direct pipeline-to-SRAM wiring and adds width scaling, wait states, address translation and a completion handshake.

## Interface
- DATA_W, 32, pipeline data width; integer multiple of DQ_W (BEATS = DATA_W/DQ_W, ≥1)
- DQ_W, 16, SRAM data bus width
- SRAM_ADDR_W, 18, SRAM address width
- WAIT, 1, extra cycles per beat (beat length = WAIT+1 cycles), 0..15
- BASE_ADDR, 1024, byte address mapped to SRAM word 0

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- rd_en  in  1  load request, held by requester until `ready`
- wr_en  in  1  store request, held by requester until `ready`
- addr  in  32  byte address
- wdata  in  DATA_W  store data, sampled at request acceptance
- rdata  out  DATA_W  load data, registered, valid when `ready` rises after a load
- ready  out  1  high = no access pending / access done; low = freeze
- sram_address  out  SRAM_ADDR_W  SRAM word address
- sram_we_n  out  1  SRAM write enable, active low
- sram_dq  inout  DQ_W  SRAM data; driven only while sram_we_n=0, else high-Z

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: ready = !(rd_en | wr_en). On rd_en|wr_en: latch op, wdata and base = ((addr − BASE_ADDR) >> log2(DATA_W/8)) × BEATS, truncated to SRAM_ADDR_W bits. Go to ACCESS with beat=0, wcnt=0.
- rd_en and wr_en both high: write wins.
- ACCESS: sram_address = base + beat. Writes: sram_we_n=0 every cycle of the beat, sram_dq = wdata[beat×DQ_W +: DQ_W]. Reads: sram_we_n=1, sram_dq high-Z, on last cycle of beat (wcnt==WAIT) capture sram_dq into rdata[beat×DQ_W +: DQ_W]. wcnt counts 0..WAIT; at WAIT, wcnt←0, beat←beat+1. After last cycle of beat BEATS−1, go to DONE. ready=0.
- DONE: ready=1 for exactly one cycle, sram_we_n=1, then IDLE. A request still asserted in the following IDLE cycle starts a new access. The requester must drop or replace its request in the cycle after DONE.
- Beat order: beat 0 = least-significant DQ_W slice at the lowest SRAM address (little-endian).
- Low addr bits below the word size are ignored. Addresses below BASE_ADDR or beyond SRAM range wrap modulo 2^SRAM_ADDR_W.
- Request dropped during ACCESS: the access still completes; no abort.
- rdata is unchanged by stores and holds the last load value.

## Timing
- Reset values: state=IDLE, rdata=0, sram_address=0, sram_we_n=1, sram_dq high-Z, ready = !(rd_en|wr_en).
- Latency: request seen in IDLE at cycle 0; ready low for 1+BEATS×(WAIT+1) cycles, high in DONE. Defaults: 5 low cycles, ready high on 6th.
- rst asserted mid-access: immediate (async) return to IDLE. sram_we_n=1 and dq released the same instant. A partial write is left in SRAM. rdata=0.
- All outputs except ready (IDLE term) are registered.

## Structure
- Package sram_ctrl_pkg: state enum (IDLE/ACCESS/DONE), function computing BEATS and beat-index width, default parameter constants.
- One sub-module is natural: sram_ctrl_timer (wcnt/beat counters with beat_last/access_last flags). FSM, datapath and tristate stay in sram_ctrl.
- The bench uses a parametrised behavioural SRAM model with width DQ_W and depth ≥ 2^10 words.

## Test plan
- Defaults, store 0xDEADBEEF at addr 1024 → SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; ready low exactly 5 cycles, high 1 cycle.
- Load from 1024 after that store → rdata=0xDEADBEEF when ready rises. Load from 1028 after storing 0x12345678 there → SRAM[2]=0x5678, SRAM[3]=0x1234, rdata=0x12345678.
- rd_en=wr_en=1 at 1032 with wdata=0xA5A5_5A5A → write performed (SRAM[4]=0x5A5A, SRAM[5]=0xA5A5); rdata unchanged.
- WAIT=0 → ready low 3 cycles. WAIT=3 → ready low 9 cycles. DATA_W=64 → store of 0x0011223344556677 fills SRAM[0..3]=0x6677,0x4455,0x2233,0x0011; ready low 1+4×2=9 cycles.
- rst pulled low in 2nd ACCESS cycle of a store → sram_we_n=1 and dq=Z immediately. After release, state IDLE and rdata=0. A new load completes normally.
- Back-to-back loads held across DONE → second access starts in the IDLE cycle after DONE; ready pattern 0×5,1,0×5,1.
